// File: rtl/matrix_pkg.sv
// Shared definitions for the chunked matrix reader/writer pair: FSM encoding
// and the size helpers both sides use to dimension their counters.
package matrix_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    FILL  = ST_FILL,
    FLUSH = ST_FLUSH,
    DONE  = ST_DONE
  } writer_state_t;

  function automatic int n2_of(input int matrix_size);
    return matrix_size * matrix_size;
  endfunction

  // Bits needed to hold every value 0..max_count inclusive.
  function automatic int cnt_width(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/chunk_buffer.sv
// Small register file holding one chunk of (address, data) entries between
// arrival on the stream side and the burst to memory.
module chunk_buffer #(
  parameter int depth     = 4,
  parameter int width     = 16,
  parameter int idx_width = (depth > 1) ? $clog2(depth) : 1
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [idx_width-1:0] wr_idx,
  input  logic [width-1:0]     wr_data,
  input  logic [idx_width-1:0] rd_idx,
  output logic [width-1:0]     rd_data
);

  logic [width-1:0] mem_q [depth];

  // NOTE: storage is deliberately left without reset; every entry is written
  // before it is read, and a reset port here would only cost flops and fanout.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/matrix_writer.sv
// Stream-to-memory writeback engine: gathers (addr, data) pairs into chunks
// and bursts each full chunk to the result memory, pulsing done after N2 writes.
module matrix_writer
  import matrix_pkg::*;
#(
  parameter int addr_width  = 8,
  parameter int data_width  = 8,
  parameter int chunk_size  = 4,
  parameter int matrix_size = 8,
  parameter int base_addr   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  start,
  input  logic [addr_width-1:0] in_addr,
  input  logic [data_width-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [addr_width-1:0] mem_addr,
  output logic [data_width-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int N2    = n2_of(matrix_size);
  localparam int TOT_W = cnt_width(N2);
  localparam int PTR_W = cnt_width(chunk_size);
  localparam int IDX_W = (chunk_size > 1) ? $clog2(chunk_size) : 1;
  localparam int ENT_W = addr_width + data_width;

  localparam logic [TOT_W-1:0]      TOTAL_FULL = TOT_W'(N2);
  localparam logic [PTR_W-1:0]      PTR_LAST   = PTR_W'(chunk_size - 1);
  localparam logic [addr_width-1:0] BASE       = addr_width'(base_addr);

  writer_state_t    state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [TOT_W-1:0] total_q, total_d;
  logic             err_q, err_d;

  logic             accept;
  logic             in_range;
  logic             buf_we;
  logic             flushing;
  logic [ENT_W-1:0] rd_entry;

  assign accept   = (state_q == FILL) && enable && in_valid;
  assign in_range = 32'(in_addr) < N2;
  assign buf_we   = accept && in_range;
  assign flushing = (state_q == FLUSH);

  chunk_buffer #(
    .depth     (chunk_size),
    .width     (ENT_W),
    .idx_width (IDX_W)
  ) u_chunk_buffer (
    .clk     (clk),
    .we      (buf_we),
    .wr_idx  (wr_ptr_q[IDX_W-1:0]),
    .wr_data ({in_addr, in_data}),
    .rd_idx  (rd_ptr_q[IDX_W-1:0]),
    .rd_data (rd_entry)
  );

  // NOTE: every next-state signal takes its hold value first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    total_d  = total_q;
    err_d    = err_q;

    case (state_q)
      IDLE: begin
        if (enable && start) begin
          state_d  = FILL;
          err_d    = 1'b0;
          total_d  = '0;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
        end
      end
      FILL: begin
        if (buf_we) begin
          wr_ptr_d = wr_ptr_q + PTR_W'(1);
          total_d  = total_q + TOT_W'(1);
          if (wr_ptr_q == PTR_LAST) begin
            state_d = FLUSH;
          end
        end else if (accept) begin
          err_d = 1'b1;
        end
      end
      FLUSH: begin
        if (enable) begin
          if (rd_ptr_q == PTR_LAST) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            state_d  = (total_q == TOTAL_FULL) ? DONE : FILL;
          end else begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
          end
        end
      end
      DONE: begin
        if (enable) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      total_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      total_q  <= total_d;
      err_q    <= err_d;
    end
  end

  // Memory-side outputs are gated by state so they read zero outside a burst.
  assign in_ready  = (state_q == FILL) && enable;
  assign mem_we    = flushing && enable;
  assign mem_addr  = flushing ? BASE + rd_entry[ENT_W-1:data_width] : '0;
  assign mem_wdata = flushing ? rd_entry[data_width-1:0] : '0;
  assign busy      = (state_q == FILL) || flushing;
  assign done      = (state_q == DONE);
  assign err       = err_q;

endmodule

// File: tb/tb_matrix_writer.sv
// Bench for matrix_writer: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_matrix_writer;

  localparam int N2 = 64;
  localparam int CH = 4;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b1;
  logic       start = 1'b0;
  logic [7:0] in_addr = 8'd0;
  logic [7:0] in_data = 8'd0;
  logic       in_valid = 1'b0;
  logic       in_ready, mem_we, busy, done, err;
  logic [7:0] mem_addr, mem_wdata;

  logic       b_enable = 1'b1;
  logic       b_start = 1'b0;
  logic [7:0] b_addr = 8'd0;
  logic [7:0] b_data = 8'd0;
  logic       b_valid = 1'b0;
  logic       b_in_ready, b_mem_we, b_busy, b_done, b_err;
  logic [7:0] b_mem_addr, b_mem_wdata;

  int total = 0;
  int bad = 0;

  // statistics maintained by the monitor, read as deltas by the stimulus
  int cyc = 0, wr_cnt = 0, done_cnt = 0, wr70_cnt = 0;
  int gap4_cnt = 0, gapx_cnt = 0, cyc_wr63 = 0, cyc_done = 0;
  logic [7:0] shadow [256];

  matrix_writer #(
    .addr_width(8), .data_width(8), .chunk_size(CH), .matrix_size(8), .base_addr(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .start(start),
    .in_addr(in_addr), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .busy(busy), .done(done), .err(err)
  );

  matrix_writer #(
    .addr_width(8), .data_width(8), .chunk_size(CH), .matrix_size(8), .base_addr(250)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(b_enable), .start(b_start),
    .in_addr(b_addr), .in_data(b_data), .in_valid(b_valid), .in_ready(b_in_ready),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_we(b_mem_we),
    .busy(b_busy), .done(b_done), .err(b_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a pass collects accepted in-range elements; every CH of
  // them become a pending burst that drains one entry per enabled cycle.
  initial begin : monitor
    ent_t        m_buf[$];
    ent_t        m_wq[$];
    ent_t        head;
    bit          m_active, m_done, m_err, pend;
    int          m_total, gap_run;
    logic [20:0] exp_vec, act_vec;
    m_active = 0; m_done = 0; m_err = 0; m_total = 0; gap_run = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        m_active = 0; m_done = 0; m_err = 0; m_total = 0;
        m_buf.delete();
        m_wq.delete();
      end
      pend = (m_wq.size() != 0);
      head = '0;
      if (pend) head = m_wq[0];
      exp_vec = {m_active && !pend && enable, pend && enable, head.a, head.d,
                 m_active, m_done, m_err};
      act_vec = {in_ready, mem_we, mem_addr, mem_wdata, busy, done, err};
      check("cycle", 32'(act_vec), 32'(exp_vec));

      if (mem_we === 1'b1) begin
        wr_cnt++;
        shadow[mem_addr] = mem_wdata;
        if (mem_addr == 8'd70) wr70_cnt++;
        if (mem_addr == 8'd63) cyc_wr63 = cyc;
      end
      if (done === 1'b1) begin
        done_cnt++;
        cyc_done = cyc;
      end
      if (busy && !in_ready && enable) gap_run++;
      else if (in_ready) begin
        if (gap_run == 4) gap4_cnt++;
        else if (gap_run > 0) gapx_cnt++;
        gap_run = 0;
      end
      if (!busy) gap_run = 0;

      if (rst_n && enable) begin
        if (m_done) m_done = 0;
        else if (!m_active) begin
          if (start) begin
            m_active = 1; m_err = 0; m_total = 0;
            m_buf.delete();
          end
        end else if (pend) begin
          void'(m_wq.pop_front());
          if (m_wq.size() == 0 && m_total == N2) begin
            m_active = 0;
            m_done = 1;
          end
        end else if (in_valid) begin
          if (in_addr < N2) begin
            m_buf.push_back({in_addr, in_data});
            m_total++;
            if (m_buf.size() == CH) begin
              m_wq = m_buf;
              m_buf.delete();
            end
          end else m_err = 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] d);
    bit ok = 0;
    int guard = 0;
    in_addr = a;
    in_data = d;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      ok = (in_ready === 1'b1);
      tick();
      guard++;
    end while (!ok && guard < 100);
    if (!ok) check("send_timeout", 32'(ok), 32'd1);
  endtask

  task automatic wait_done(input string name);
    bit seen = 0;
    int guard = 0;
    while (!seen && guard < 300) begin
      @(negedge clk);
      seen = (done === 1'b1);
      guard++;
    end
    tick();
    check(name, 32'(seen), 32'd1);
  endtask

  task automatic check_mem(input string name, input logic [7:0] xor_k, input logic [7:0] add_k);
    int errs = 0;
    for (int i = 0; i < N2; i++) begin
      logic [7:0] want;
      want = (8'(i) ^ xor_k) + add_k;
      if (shadow[i] !== want) errs++;
    end
    check(name, 32'(errs), 32'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int w0, d0, g4, gx, w70;
    ent_t bq[$];

    // reset values
    repeat (3) tick();
    check("rst_outputs", 32'({in_ready, mem_we, mem_addr, mem_wdata, busy, done, err}), 32'd0);
    rst_n = 1'b1;
    tick();

    // pass 1: continuous stream 0..63, data = addr + 1
    w0 = wr_cnt; d0 = done_cnt; g4 = gap4_cnt; gx = gapx_cnt;
    pulse_start();
    check("ready_after_start", 32'(in_ready), 32'd1);
    for (int i = 0; i < N2; i++) send(8'(i), 8'(i + 1));
    in_valid = 1'b0;
    wait_done("t1_done");
    check("t1_writes", 32'(wr_cnt - w0), 32'd64);
    check("t1_done_pulses", 32'(done_cnt - d0), 32'd1);
    check("t1_gaps_of_4", 32'(gap4_cnt - g4), 32'd15);
    check("t1_other_gaps", 32'(gapx_cnt - gx), 32'd0);
    check("t1_done_after_63", 32'(cyc_done - cyc_wr63), 32'd1);
    check_mem("t1_mem", 8'h00, 8'd1);

    // pass 2: valid gaps and enable low for 3 cycles inside chunk 2's burst
    w0 = wr_cnt; d0 = done_cnt;
    pulse_start();
    for (int i = 0; i < N2; i++) begin
      send(8'(i), 8'(i) ^ 8'hA5);
      if (i == 7) begin
        in_valid = 1'b0;
        tick();
        enable = 1'b0;
        repeat (3) tick();
        enable = 1'b1;
      end else if (i % 3 == 0) begin
        in_valid = 1'b0;
        tick();
      end
    end
    in_valid = 1'b0;
    wait_done("t2_done");
    check("t2_writes", 32'(wr_cnt - w0), 32'd64);
    check("t2_done_pulses", 32'(done_cnt - d0), 32'd1);
    check_mem("t2_mem", 8'hA5, 8'd0);

    // pass 3: out-of-range address 70 inside chunk 1
    w0 = wr_cnt; d0 = done_cnt; w70 = wr70_cnt;
    pulse_start();
    send(8'd0, 8'd3);
    send(8'd70, 8'hEE);
    check("t3_err_set", 32'(err), 32'd1);
    for (int i = 1; i < N2; i++) send(8'(i), 8'(i + 3));
    in_valid = 1'b0;
    wait_done("t3_done");
    check("t3_writes", 32'(wr_cnt - w0), 32'd64);
    check("t3_no_write_70", 32'(wr70_cnt - w70), 32'd0);
    check("t3_err_sticky", 32'(err), 32'd1);
    check_mem("t3_mem", 8'h00, 8'd3);

    // new start clears err; then reset after 2 of 4 burst writes
    pulse_start();
    check("err_cleared", 32'(err), 32'd0);
    for (int i = 0; i < CH; i++) send(8'(i), 8'hC0 + 8'(i));
    in_valid = 1'b0;
    w0 = wr_cnt;
    tick();
    tick();
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_we", 32'(mem_we), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_writes", 32'(wr_cnt - w0), 32'd2);
    check("rst_mem_kept", 32'({shadow[0], shadow[1], shadow[2]}), 32'hC0C105);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // full pass after reset, with a start pulse while busy
    w0 = wr_cnt; d0 = done_cnt;
    pulse_start();
    for (int i = 0; i < N2; i++) begin
      if (i == 20) start = 1'b1;
      send(8'(i), 8'(i) ^ 8'h40);
      start = 1'b0;
    end
    in_valid = 1'b0;
    wait_done("t5_done");
    check("t5_writes", 32'(wr_cnt - w0), 32'd64);
    check("t5_done_pulses", 32'(done_cnt - d0), 32'd1);
    check_mem("t5_mem", 8'h40, 8'd0);

    // base_addr = 250 instance: addresses 10..13 wrap to 4..7
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    for (int i = 0; i < CH; i++) begin
      bit ok = 0;
      int guard = 0;
      b_addr = 8'd10 + 8'(i);
      b_data = 8'h90 + 8'(i);
      b_valid = 1'b1;
      do begin
        @(negedge clk);
        ok = (b_in_ready === 1'b1);
        tick();
        guard++;
      end while (!ok && guard < 50);
      if (!ok) check("b_send_timeout", 32'(ok), 32'd1);
    end
    b_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (b_mem_we === 1'b1) bq.push_back({b_mem_addr, b_mem_wdata});
    end
    check("b_write_count", 32'(bq.size()), 32'd4);
    if (bq.size() == 4) begin
      check("b_first_wrap", 32'(bq[0]), 32'h0490);
      for (int i = 1; i < 4; i++)
        check("b_wrap_seq", 32'(bq[i]), 32'({8'd4 + 8'(i), 8'h90 + 8'(i)}));
    end
    check("b_status", 32'({b_busy, b_done, b_err}), 32'b100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
